// File: rtl/ram_burst_reader.sv
// ---------------------------------------------------------------------------
// ram_burst_reader
//
// Reads a burst of consecutive words from a combinational-read RAM and streams
// them out over a valid/ready handshake. The RAM address wraps modulo
// 2^ADDRESS_WIDTH. One word per cycle is sustained while the sink holds ready
// high.
//
// Optional feature (compile-time macro):
//   RAM_BURST_READER_CHECKSUM_EN - builds a running checksum (modulo
//   2^BUS_WIDTH sum of every transferred word). The checksum is cleared on an
//   accepted start and holds after done until the next start. When the macro
//   is undefined, checksum is tied to 0 and no accumulator exists.
//
// Ports:
//   clk       in   clock, rising edge
//   rst       in   asynchronous active-high reset
//   start     in   begin a burst (sampled in IDLE only)
//   base      in   first RAM address of the burst (sampled with start)
//   len       in   number of words, 0 = empty burst (sampled with start)
//   abort     in   terminate the current burst, no done pulse
//   ad        out  RAM address (registered)
//   st        out  RAM store strobe, always 0
//   O         in   RAM read data, combinational in ad
//   data_out  out  streamed word (registered)
//   valid     out  data_out holds an untransferred word
//   ready     in   sink accepts data_out when valid && ready
//   busy      out  high outside IDLE
//   done      out  one-cycle pulse on normal completion
//   checksum  out  burst checksum (see above)
// ---------------------------------------------------------------------------
module ram_burst_reader #(
  parameter int BUS_WIDTH     = 8,
  parameter int ADDRESS_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [ADDRESS_WIDTH-1:0] base,
  input  logic [ADDRESS_WIDTH-1:0] len,
  input  logic                     abort,
  output logic [ADDRESS_WIDTH-1:0] ad,
  output logic                     st,
  input  logic [BUS_WIDTH-1:0]     O,
  output logic [BUS_WIDTH-1:0]     data_out,
  output logic                     valid,
  input  logic                     ready,
  output logic                     busy,
  output logic                     done,
  output logic [BUS_WIDTH-1:0]     checksum
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                   r_state;
  state_t                   w_next;

  logic [ADDRESS_WIDTH-1:0] r_ad;
  logic [ADDRESS_WIDTH-1:0] r_remaining;
  logic [BUS_WIDTH-1:0]     r_data;
  logic                     r_valid;
  logic                     r_done;

  logic                     w_busy;
  logic                     w_accept;
  logic                     w_load;
  logic                     w_xfer;
  logic                     w_kill;
  logic                     w_done_set;
  logic                     w_last;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        // An empty burst only produces done and never leaves IDLE.
        if (start && (len != '0)) begin
          w_next = S_FETCH;
        end
      end
      S_FETCH: begin
        if (abort) begin
          w_next = S_IDLE;
        end else if (w_load && w_last) begin
          w_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (abort || (r_valid && ready)) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    w_busy     = (r_state != S_IDLE);
    w_accept   = (r_state == S_IDLE) && start;
    w_kill     = w_busy && abort;
    // A new word may be fetched when the output register is empty or is being
    // emptied this cycle; abort overrides any handshake.
    w_load     = (r_state == S_FETCH) && !abort && (!r_valid || ready);
    w_xfer     = r_valid && ready && !abort;
    w_last     = (r_remaining == ADDRESS_WIDTH'(1));
    w_done_set = (w_accept && (len == '0)) ||
                 ((r_state == S_DRAIN) && w_xfer);
  end

  // Address, word counter, output word and handshake registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ad        <= '0;
      r_remaining <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= w_done_set;

      if (w_accept && (len != '0)) begin
        r_ad        <= base;
        r_remaining <= len;
      end else if (w_load) begin
        r_data      <= O;
        r_ad        <= r_ad + ADDRESS_WIDTH'(1);
        r_remaining <= r_remaining - ADDRESS_WIDTH'(1);
      end

      if (w_kill) begin
        r_valid <= 1'b0;
      end else if (w_load) begin
        r_valid <= 1'b1;
      end else if (w_xfer) begin
        r_valid <= 1'b0;
      end
    end
  end

`ifdef RAM_BURST_READER_CHECKSUM_EN
  logic [BUS_WIDTH-1:0] r_checksum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_checksum <= '0;
    end else if (w_accept) begin
      r_checksum <= '0;
    end else if (w_xfer) begin
      r_checksum <= r_checksum + r_data;
    end
  end

  assign checksum = r_checksum;
`else
  assign checksum = '0;
`endif

  assign ad       = r_ad;
  assign st       = 1'b0;
  assign data_out = r_data;
  assign valid    = r_valid;
  assign busy     = w_busy;
  assign done     = r_done;

endmodule

// File: tb/tb_ram_burst_reader.sv
// ---------------------------------------------------------------------------
// tb_ram_burst_reader
//
// Scoreboard bench for ram_burst_reader (BUS_WIDTH=8, ADDRESS_WIDTH=8).
// The stimulus side pushes the expected word stream (mem[(base+i) mod 256])
// and the expected completion checksum when it issues a burst; a monitor pops
// and compares whenever a handshake or a done pulse is presented.
// ---------------------------------------------------------------------------
module tb_ram_burst_reader;

  localparam int BW = 8;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base;
  logic [AW-1:0] len;
  logic          abort;
  logic [AW-1:0] ad;
  logic          st;
  logic [BW-1:0] O;
  logic [BW-1:0] data_out;
  logic          valid;
  logic          ready;
  logic          busy;
  logic          done;
  logic [BW-1:0] checksum;

  logic [BW-1:0] mem [256];

  int n_vec = 0;
  int n_err = 0;

  logic [BW-1:0] exp_q[$];
  logic [BW-1:0] done_q[$];

  ram_burst_reader #(.BUS_WIDTH(BW), .ADDRESS_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .base(base), .len(len),
    .abort(abort), .ad(ad), .st(st), .O(O), .data_out(data_out),
    .valid(valid), .ready(ready), .busy(busy), .done(done),
    .checksum(checksum)
  );

  always #5 clk = ~clk;

  assign O = mem[ad];

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: inputs change just after the rising edge, so values seen on the
  // falling edge are exactly what the next rising edge samples.
  always @(negedge clk) begin
    if (!rst) begin
      if (valid && ready && !abort) begin
        if (exp_q.size() == 0) begin
          chk("extra_beat", 32'(data_out), -1);
        end else begin
          chk("beat", 32'(data_out), 32'(exp_q.pop_front()));
        end
      end
      if (done) begin
        if (done_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          chk("done_checksum", 32'(checksum), 32'(done_q.pop_front()));
        end
      end
    end
  end

  // Reference: the burst is mem[base], mem[base+1], ... with 8-bit address
  // wrap; checksum is their byte sum (0 when the feature is not built).
  task automatic issue(input int b, input int l, input bit exp_done);
    logic [BW-1:0] sum;
    sum   = '0;
    start = 1'b1;
    base  = AW'(b);
    len   = AW'(l);
    for (int i = 0; i < l; i++) begin
      exp_q.push_back(mem[(b + i) % 256]);
      sum = sum + mem[(b + i) % 256];
    end
`ifndef RAM_BURST_READER_CHECKSUM_EN
    sum = '0;
`endif
    if (exp_done) done_q.push_back(sum);
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input bit rnd, input bit poke);
    int n;
    n = 0;
    while (busy && n < 3000) begin
      ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (poke && $urandom_range(0, 7) == 0) begin
        start = 1'b1;
        base  = AW'($urandom);
        len   = AW'($urandom_range(1, 9));
      end else begin
        start = 1'b0;
      end
      tick();
      n++;
    end
    start = 1'b0;
    ready = 1'b1;
    if (busy) chk("timeout_busy", 1, 0);
    tick();
    chk("queue_drained", exp_q.size(), 0);
    chk("done_drained", done_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int b;
    int l;
    rst   = 1'b1;
    start = 1'b0;
    base  = '0;
    len   = '0;
    abort = 1'b0;
    ready = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = BW'(i + 1);
    #1;
    chk("rst_ad", 32'(ad), 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_data", 32'(data_out), 0);
    chk("rst_checksum", 32'(checksum), 0);
    chk("st_zero", 32'(st), 0);
    tick();
    tick();
    rst = 1'b0;

    // Basic burst with ready held high: 5,6,7 back to back.
    issue(4, 3, 1);
    chk("lat_ad", 32'(ad), 4);
    chk("lat_busy", 32'(busy), 1);
    tick();
    chk("b1_valid", 32'(valid), 1);
    chk("b1_data", 32'(data_out), 5);
    tick();
    chk("b2_data", 32'(data_out), 6);
    tick();
    chk("b3_data", 32'(data_out), 7);
    tick();
    chk("end_done", 32'(done), 1);
    chk("end_valid", 32'(valid), 0);
    chk("end_busy", 32'(busy), 0);
`ifdef RAM_BURST_READER_CHECKSUM_EN
    chk("sum18", 32'(checksum), 18);
`else
    chk("sum_off", 32'(checksum), 0);
`endif
    wait_idle(0, 0);

    // Address wrap past 255.
    issue(254, 4, 1);
    chk("wrap_ad0", 32'(ad), 254);
    tick();
    chk("wrap_ad1", 32'(ad), 255);
    tick();
    chk("wrap_ad2", 32'(ad), 0);
    tick();
    chk("wrap_ad3", 32'(ad), 1);
    wait_idle(0, 0);

    // Stall three cycles after the first word; a start pulse while busy
    // must not disturb the address.
    issue(10, 3, 1);
    tick();
    chk("stall_first", 32'(data_out), 32'(mem[10]));
    ready = 1'b0;
    start = 1'b1;
    base  = 8'd99;
    len   = 8'd7;
    for (int k = 0; k < 3; k++) begin
      tick();
      start = 1'b0;
      chk("stall_valid", 32'(valid), 1);
      chk("stall_data", 32'(data_out), 32'(mem[10]));
      chk("stall_ad", 32'(ad), 11);
    end
    ready = 1'b1;
    wait_idle(0, 0);

    // Empty burst.
    issue(7, 0, 1);
    chk("len0_done", 32'(done), 1);
    chk("len0_busy", 32'(busy), 0);
    chk("len0_valid", 32'(valid), 0);
    tick();
    chk("len0_done_off", 32'(done), 0);
    chk("len0_valid2", 32'(valid), 0);
    chk("len0_busy2", 32'(busy), 0);
    chk("len0_drained", done_q.size(), 0);

    // Random contents for the remaining tests.
    for (int i = 0; i < 256; i++) mem[i] = BW'($urandom);

    // Abort on the second beat while ready is high.
    issue(20, 5, 0);
    tick();
    tick();
    chk("ab_second", 32'(data_out), 32'(mem[21]));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("ab_valid", 32'(valid), 0);
    chk("ab_busy", 32'(busy), 0);
    chk("ab_done", 32'(done), 0);
    exp_q.delete();
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("ab_no_done", 32'(done), 0);
    end

    // Start together with abort in IDLE still starts.
    abort = 1'b1;
    issue(30, 2, 1);
    abort = 1'b0;
    chk("startab_busy", 32'(busy), 1);
    chk("startab_ad", 32'(ad), 30);
    wait_idle(0, 0);

    // Reset mid-burst, then start on the first edge after release.
    issue(40, 5, 0);
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    chk("mrst_ad", 32'(ad), 0);
    chk("mrst_valid", 32'(valid), 0);
    chk("mrst_busy", 32'(busy), 0);
    chk("mrst_done", 32'(done), 0);
    chk("mrst_data", 32'(data_out), 0);
    chk("mrst_checksum", 32'(checksum), 0);
    exp_q.delete();
    tick();
    rst = 1'b0;
    issue(50, 2, 1);
    chk("post_rst_ad", 32'(ad), 50);
    chk("post_rst_busy", 32'(busy), 1);
    wait_idle(0, 0);

    // Maximum length burst with random backpressure and stray starts.
    b = int'($urandom_range(0, 255));
    issue(b, 255, 1);
    chk("max_ad", 32'(ad), b);
    wait_idle(1, 1);

    // Random bursts.
    for (int k = 0; k < 25; k++) begin
      b = int'($urandom_range(0, 255));
      l = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 20));
      issue(b, l, 1);
      if (l != 0) chk("rnd_lat_ad", 32'(ad), b);
      wait_idle(1, 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ram_burst_reader.md
RAM_BURST_READER -- requirements
Module: ram_burst_reader

Interface
REQ-001 Parameter BUS_WIDTH, default 8: width of a RAM word and of data_out.
REQ-002 Parameter ADDRESS_WIDTH, default 8: RAM address width; the RAM holds 2^ADDRESS_WIDTH words.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  one-cycle request to begin a burst; sampled only in IDLE.
REQ-006 base  input  ADDRESS_WIDTH  first RAM address of the burst, sampled with start.
REQ-007 len  input  ADDRESS_WIDTH  number of words to read, sampled with start; 0 = empty burst.
REQ-008 abort  input  1  terminates the current burst.
REQ-009 ad  output  ADDRESS_WIDTH  RAM address; registered.
REQ-010 st  output  1  RAM store strobe; constant 0.
REQ-011 O  input  BUS_WIDTH  RAM read data; combinational function of ad.
REQ-012 data_out  output  BUS_WIDTH  streamed word; registered.
REQ-013 valid  output  1  data_out holds an untransferred word.
REQ-014 ready  input  1  sink accepts data_out when valid and ready are both high.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 done  output  1  one-cycle pulse at normal burst completion.
REQ-017 checksum  output  BUS_WIDTH  burst checksum; see Configuration.

Function
REQ-018 The FSM SHALL have three states: IDLE, FETCH and DRAIN.
REQ-019 IDLE: start with len!=0 SHALL load ad<=base and remaining<=len, then enter FETCH.
REQ-020 IDLE: start with len==0 SHALL pulse done on the next cycle, produce no beat, and remain in IDLE.
REQ-021 FETCH: when valid==0 or ready==1, the block SHALL load data_out<=O, set valid<=1, advance ad<=ad+1 modulo 2^ADDRESS_WIDTH, and decrement remaining.
REQ-022 FETCH: when remaining reaches 0 after that load, the block SHALL enter DRAIN.
REQ-023 FETCH: when valid==1 and ready==0, ad, data_out and remaining SHALL hold.
REQ-024 DRAIN: on valid and ready both high, the block SHALL clear valid, pulse done for one cycle, and return to IDLE.
REQ-025 Throughput SHALL be one word per cycle while ready is held high.
REQ-026 Latency SHALL be as follows: start sampled at edge N gives ad=base after N; valid=1 with data_out=mem[base] after edge N+1.
REQ-027 The block SHALL emit beats in address order base, base+1, ... with wrap-around past 2^ADDRESS_WIDTH-1 to 0.
REQ-028 start while busy SHALL be ignored.
REQ-029 abort in FETCH or DRAIN SHALL clear valid and return to IDLE on the next edge with no done pulse; abort takes priority over a simultaneous handshake.
REQ-030 abort in IDLE SHALL have no effect; start and abort together in IDLE SHALL start the burst.
REQ-031 A len equal to 2^ADDRESS_WIDTH-1 SHALL be a legal burst length.

Reset
REQ-032 rst SHALL, asynchronously, force state=IDLE, ad=0, remaining=0, data_out=0, valid=0, done=0, busy=0, checksum=0.
REQ-033 rst asserted mid-burst SHALL discard the burst with no done pulse.
REQ-034 The first start SHALL be honoured on the first rising edge after rst deasserts.

Configuration
REQ-035 With RAM_BURST_READER_CHECKSUM_EN defined, checksum SHALL be cleared on an accepted start and add each transferred word modulo 2^BUS_WIDTH; it SHALL be stable and valid while done=1 and hold until the next start.
REQ-036 Without RAM_BURST_READER_CHECKSUM_EN, checksum SHALL be constant 0 and no accumulator SHALL be built.

Verification
REQ-037 Stimulus: mem[i]=i+1; start base=4 len=3; ready=1. Response: beats 5,6,7 on consecutive cycles; done one cycle after the last beat; checksum=18 when enabled.
REQ-038 Stimulus: base=254 len=4, ADDRESS_WIDTH=8. Response: ad sequence 254,255,0,1; beats mem[254],mem[255],mem[0],mem[1].
REQ-039 Stimulus: len=3, ready low for 3 cycles after the first valid. Response: data_out and ad held; no beat lost or duplicated; exactly 3 transfers.
REQ-040 Stimulus: start len=0. Response: done pulses once, valid never rises, busy stays 0.
REQ-041 Stimulus: abort on the 2nd beat of len=5, then rst mid-burst of a new len=5. Response: valid=0 next cycle, no done, IDLE; all outputs 0 immediately on rst.
REQ-042 Stimulus: start pulses during a burst. Response: ignored, with no change to ad or remaining.
